// File: rtl/map_fetch_arbiter_pkg.sv
// Shared constants, tile-type codes and arbiter FSM encodings for the
// tile-map fetch path.
package map_fetch_arbiter_pkg;

  localparam int TILE_BITS  = 5;
  localparam int MAP_ADDR_W = 8;
  localparam int TYPE_W     = 4;

  localparam logic [TYPE_W-1:0] GROUND = 4'h0;
  localparam logic [TYPE_W-1:0] FOOD   = 4'h1;
  localparam logic [TYPE_W-1:0] HEAD_L = 4'hC;
  localparam logic [TYPE_W-1:0] HEAD_U = 4'hD;
  localparam logic [TYPE_W-1:0] HEAD_R = 4'hE;
  localparam logic [TYPE_W-1:0] HEAD_D = 4'hF;

  typedef enum logic [1:0] {
    GM_IDLE  = 2'd0,
    GM_ISSUE = 2'd1,
    GM_ACK   = 2'd2
  } gm_state_t;

  // Map RAM address of a tile: row in the upper nibble, column in the lower.
  function automatic logic [MAP_ADDR_W-1:0] map_addr(input logic [3:0] row,
                                                     input logic [3:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/map_fetch_arbiter_render_prefetch.sv
// Render-side prefetch: works out which tile comes next, requests its type
// from the map RAM at a fixed pixel slot, and hands it to tile_type on
// entry to that tile.
module render_prefetch
  import map_fetch_arbiter_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MAP_COLS   = 16,
  parameter int MAP_ROWS   = 16,
  parameter int FETCH_SLOT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic [TYPE_W-1:0]     ram_rdata,
  output logic                  render_req,
  output logic [MAP_ADDR_W-1:0] render_addr,
  output logic [TYPE_W-1:0]     tile_type
);

  localparam logic [9:0]           H_LAST_TILE = 10'(H_ACTIVE - 32);
  localparam logic [9:0]           H_ACT       = 10'(H_ACTIVE);
  localparam logic [9:0]           V_ACT       = 10'(V_ACTIVE);
  localparam logic [9:0]           V_LAST      = 10'(V_ACTIVE - 1);
  localparam logic [5:0]           COLS_LIM    = 6'(MAP_COLS);
  localparam logic [5:0]           ROWS_LIM    = 6'(MAP_ROWS);
  localparam logic [TILE_BITS-1:0] SLOT        = TILE_BITS'(FETCH_SLOT);
  localparam logic [TILE_BITS-1:0] LAST_PIX    = 5'd31;

  logic              active_s;
  logic              slot_s;
  logic              in_map_s;
  logic [5:0]        ncol_s;
  logic [5:0]        nrow_s;
  logic [10:0]       py_inc_s;
  logic              fetch_d_r;
  logic              in_map_d_r;
  logic [TYPE_W-1:0] next_type_r;
  logic [TYPE_W-1:0] tile_type_r;

  // Next-tile coordinates, map bounds test and render slot decode.
  always_comb begin
    active_s = (pix_x < H_ACT) && (pix_y < V_ACT);
    py_inc_s = {1'b0, pix_y} + 11'd1;
    if (pix_x < H_LAST_TILE) begin
      ncol_s = {1'b0, pix_x[9:TILE_BITS]} + 6'd1;
      nrow_s = {1'b0, pix_y[9:TILE_BITS]};
    end else begin
      ncol_s = 6'd0;
      if (pix_y == V_LAST) begin
        nrow_s = 6'd0;
      end else begin
        nrow_s = py_inc_s[10:TILE_BITS];
      end
    end
    in_map_s    = (ncol_s < COLS_LIM) && (nrow_s < ROWS_LIM);
    slot_s      = active_s && (pix_x[TILE_BITS-1:0] == SLOT);
    render_req  = slot_s && in_map_s;
    render_addr = map_addr(nrow_s[3:0], ncol_s[3:0]);
  end

  // Remember the slot outcome so the following cycle knows what to capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_d_r  <= 1'b0;
      in_map_d_r <= 1'b0;
    end else begin
      fetch_d_r  <= slot_s;
      in_map_d_r <= in_map_s;
    end
  end

  // Capture the prefetched type one cycle after the slot; off-map tiles are ground.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_type_r <= GROUND;
    end else if (fetch_d_r) begin
      next_type_r <= in_map_d_r ? ram_rdata : GROUND;
    end else begin
      next_type_r <= next_type_r;
    end
  end

  // Promote the prefetched type on the last pixel so it is live at the next tile's pixel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_type_r <= GROUND;
    end else if (active_s && (pix_x[TILE_BITS-1:0] == LAST_PIX)) begin
      tile_type_r <= next_type_r;
    end else begin
      tile_type_r <= tile_type_r;
    end
  end

  assign tile_type = tile_type_r;

endmodule

// File: rtl/map_fetch_arbiter.sv
// Single-port tile-map RAM arbiter: the render prefetch owns its slot each
// tile, game-logic reads/writes fill the remaining cycles via req/ack.
module map_fetch_arbiter
  import map_fetch_arbiter_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MAP_COLS   = 16,
  parameter int MAP_ROWS   = 16,
  parameter int FETCH_SLOT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  output logic [TYPE_W-1:0]     tile_type,
  input  logic                  gm_req,
  input  logic                  gm_we,
  input  logic [MAP_ADDR_W-1:0] gm_addr,
  input  logic [TYPE_W-1:0]     gm_wdata,
  output logic                  gm_ack,
  output logic [TYPE_W-1:0]     gm_rdata,
  output logic [MAP_ADDR_W-1:0] ram_addr,
  output logic                  ram_we,
  output logic [TYPE_W-1:0]     ram_wdata,
  input  logic [TYPE_W-1:0]     ram_rdata
);

  gm_state_t             state_r;
  gm_state_t             state_next_s;
  logic                  render_req_s;
  logic [MAP_ADDR_W-1:0] render_addr_s;
  logic                  gm_issue_s;
  logic                  op_we_r;
  logic                  gm_ack_r;
  logic [TYPE_W-1:0]     gm_rdata_r;

  render_prefetch #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .MAP_COLS   (MAP_COLS),
    .MAP_ROWS   (MAP_ROWS),
    .FETCH_SLOT (FETCH_SLOT)
  ) u_render_prefetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .ram_rdata   (ram_rdata),
    .render_req  (render_req_s),
    .render_addr (render_addr_s),
    .tile_type   (tile_type)
  );

  // Game-logic FSM next state plus RAM port mux: render first, then a game issue from IDLE.
  always_comb begin
    state_next_s = state_r;
    gm_issue_s   = 1'b0;
    case (state_r)
      GM_IDLE: begin
        if (gm_req && !render_req_s) begin
          gm_issue_s   = 1'b1;
          state_next_s = GM_ISSUE;
        end else begin
          state_next_s = GM_IDLE;
        end
      end
      GM_ISSUE: state_next_s = GM_ACK;
      GM_ACK:   state_next_s = GM_IDLE;
      default:  state_next_s = GM_IDLE;
    endcase

    if (render_req_s) begin
      ram_addr  = render_addr_s;
      ram_we    = 1'b0;
      ram_wdata = 4'h0;
    end else if (gm_issue_s) begin
      ram_addr  = gm_addr;
      ram_we    = gm_we;
      ram_wdata = gm_wdata;
    end else begin
      ram_addr  = 8'h00;
      ram_we    = 1'b0;
      ram_wdata = 4'h0;
    end
  end

  // FSM state register; a reset mid-access simply drops the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= GM_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Remember whether the access in flight is a write so ISSUE leaves gm_rdata alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_we_r <= 1'b0;
    end else if (gm_issue_s) begin
      op_we_r <= gm_we;
    end else begin
      op_we_r <= op_we_r;
    end
  end

  // Registered completion pulse (high for the ACK state) and read-data capture in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gm_ack_r   <= 1'b0;
      gm_rdata_r <= 4'h0;
    end else begin
      gm_ack_r <= (state_next_s == GM_ACK);
      if ((state_r == GM_ISSUE) && !op_we_r) begin
        gm_rdata_r <= ram_rdata;
      end else begin
        gm_rdata_r <= gm_rdata_r;
      end
    end
  end

  assign gm_ack   = gm_ack_r;
  assign gm_rdata = gm_rdata_r;

endmodule

// File: tb/tb_map_fetch_arbiter.sv
// Directed bench for map_fetch_arbiter with a pipelined map RAM model and
// scoreboards for render tile types and game-logic transactions.
module tb_map_fetch_arbiter;
  import map_fetch_arbiter_pkg::*;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 525;
  localparam int MAP_COLS   = 16;
  localparam int MAP_ROWS   = 16;
  localparam int FETCH_SLOT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] pix_x, pix_y;
  logic [3:0] tile_type;
  logic       gm_req, gm_we, gm_ack;
  logic [7:0] gm_addr, ram_addr;
  logic [3:0] gm_wdata, gm_rdata, ram_wdata, ram_rdata;
  logic       ram_we;

  always #5 clk = ~clk;

  map_fetch_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .tile_type(tile_type), .gm_req(gm_req), .gm_we(gm_we),
    .gm_addr(gm_addr), .gm_wdata(gm_wdata), .gm_ack(gm_ack),
    .gm_rdata(gm_rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  function automatic logic [3:0] init_val(input logic [7:0] a);
    return (a == 8'h35) ? 4'h9 : (a[7:4] ^ a[3:0]);
  endfunction

  // Pipelined single-port map RAM: data one cycle after the address.
  logic [3:0] mem [256];
  logic       load_mem;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      ram_rdata <= 4'h0;
    end else begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_wdata;
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  logic [3:0] ref_map [256];
  logic [3:0] rq [$];
  logic [3:0] cur_exp;
  bit         tt_known, upd_pend;
  logic [3:0] last_rdata;
  typedef struct { logic [3:0] rdata; int lat; } gm_exp_t;
  gm_exp_t gq [$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_active(input int x, input int y);
    return (x < H_ACTIVE) && (y < V_ACTIVE);
  endfunction

  task automatic next_tile(input int x, input int y, output bit inmap, output logic [7:0] addr);
    int nc, nr;
    if (x < H_ACTIVE - 32) begin
      nc = x / 32 + 1;
      nr = y / 32;
    end else begin
      nc = 0;
      nr = (y == V_ACTIVE - 1) ? 0 : (y + 1) / 32;
    end
    inmap = (nc < MAP_COLS) && (nr < MAP_ROWS);
    addr  = 8'((nr % 16) * 16 + (nc % 16));
  endtask

  task automatic set_pix(input int x, input int y, input bit keep);
    pix_x = 10'(x);
    pix_y = 10'(y);
    if (!keep) begin
      rq.delete();
      tt_known = 1'b0;
      upd_pend = 1'b0;
    end
  endtask

  // Advance one pixel clock and run the render scoreboard for the new cycle.
  task automatic cyc();
    bit inmap;
    logic [7:0] a;
    int x, y;
    @(posedge clk);
    #1;
    x = int'(pix_x) + 1;
    y = int'(pix_y);
    if (x == H_TOTAL) begin
      x = 0;
      y = (y + 1 == V_TOTAL) ? 0 : y + 1;
    end
    pix_x = 10'(x);
    pix_y = 10'(y);
    #1;
    if (upd_pend) begin
      upd_pend = 1'b0;
      if (rq.size() > 0) begin
        cur_exp  = rq.pop_front();
        tt_known = 1'b1;
      end else begin
        tt_known = 1'b0;
      end
    end
    if (tt_known) check("tile_type", 8'(tile_type), 8'(cur_exp));
    if (in_active(x, y) && (x % 32 == FETCH_SLOT)) begin
      next_tile(x, y, inmap, a);
      rq.push_back(inmap ? ref_map[a] : GROUND);
      if (inmap) begin
        check("slot_addr", ram_addr, a);
        check("slot_we", 8'(ram_we), 8'h00);
      end else if (!gm_req) begin
        check("oom_addr", ram_addr, 8'h00);
        check("oom_we", 8'(ram_we), 8'h00);
      end
    end
    if (in_active(x, y) && (x % 32 == 31)) upd_pend = 1'b1;
  endtask

  // One game-logic access from the current cycle, checked against the scoreboard.
  task automatic gm_access(input bit we, input logic [7:0] addr, input logic [3:0] wd, input string tag);
    bit inmap, at_slot;
    logic [7:0] ra;
    gm_exp_t e;
    int n, issue_at;
    next_tile(int'(pix_x), int'(pix_y), inmap, ra);
    at_slot = in_active(int'(pix_x), int'(pix_y)) && (pix_x[4:0] == 5'(FETCH_SLOT)) && inmap;
    gm_we = we; gm_addr = addr; gm_wdata = wd; gm_req = 1'b1;
    e.lat = at_slot ? 3 : 2;
    if (we) begin
      ref_map[addr] = wd;
      e.rdata = last_rdata;
    end else begin
      e.rdata = ref_map[addr];
      last_rdata = ref_map[addr];
    end
    gq.push_back(e);
    issue_at = at_slot ? 1 : 0;
    n = 0;
    #1;
    while (n < 8) begin
      if (at_slot && n == 0) check({tag, "_render_wins"}, ram_addr, ra);
      if (n == issue_at) begin
        check({tag, "_bus_addr"}, ram_addr, addr);
        check({tag, "_bus_we"}, 8'(ram_we), 8'(we));
        if (we) check({tag, "_bus_wdata"}, 8'(ram_wdata), 8'(wd));
      end
      if (gm_ack === 1'b1) break;
      cyc();
      n++;
    end
    e = gq.pop_front();
    check({tag, "_latency"}, 8'(n), 8'(e.lat));
    check({tag, "_ack"}, 8'(gm_ack), 8'h01);
    check({tag, "_rdata"}, 8'(gm_rdata), 8'(e.rdata));
    gm_req = 1'b0;
    cyc();
    check({tag, "_ack_pulse"}, 8'(gm_ack), 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; load_mem = 1'b1;
    gm_req = 1'b0; gm_we = 1'b0; gm_addr = 8'h00; gm_wdata = 4'h0;
    for (int i = 0; i < 256; i++) ref_map[i] = init_val(8'(i));
    last_rdata = 4'h0; cur_exp = GROUND;
    set_pix(0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    load_mem = 1'b0;
    check("por_tile", 8'(tile_type), 8'h00);
    check("por_ack", 8'(gm_ack), 8'h00);
    check("por_rdata", 8'(gm_rdata), 8'h00);
    rst_n = 1'b1;
    cur_exp = GROUND; tt_known = 1'b1;
    #1;
    check("por_state", 8'(dut.state_r), 8'(GM_IDLE));

    // Full line 0: row 0 types, cols 16..19 ground, wrap prefetch for line 1.
    repeat (800) cyc();

    // Free read at pix_x[4:0] = 3.
    repeat (3) cyc();
    gm_access(1'b0, 8'h35, 4'h0, "free_read");

    // Write collides with the render slot, then read it back.
    for (int i = 0; i < 40 && pix_x != 10'd16; i++) cyc();
    gm_access(1'b1, 8'h12, FOOD, "coll_write");
    gm_access(1'b0, 8'h12, 4'h0, "readback");
    gm_access(1'b1, 8'h00, HEAD_L, "write_origin");

    // Last tile of the last visible line prefetches map[0][0] for the next frame.
    set_pix(608, 479, 1'b0);
    repeat (16) cyc();
    check("wrap_addr", ram_addr, 8'h00);
    repeat (16) cyc();
    set_pix(0, 0, 1'b1);
    #1;
    check("frame_start", 8'(tile_type), 8'(HEAD_L));
    repeat (40) cyc();

    // Reset mid-frame while a non-ground tile is displayed.
    rst_n = 1'b0;
    #1;
    check("rst_tile", 8'(tile_type), 8'h00);
    check("rst_ack", 8'(gm_ack), 8'h00);
    check("rst_we", 8'(ram_we), 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_rdata = 4'h0;
    set_pix(64, 0, 1'b0);
    cur_exp = GROUND; tt_known = 1'b1;
    #1;
    check("rst_state", 8'(dut.state_r), 8'(GM_IDLE));

    // Reset while a read sits in ISSUE: no ack, then the request is reissued.
    repeat (3) cyc();
    gm_req = 1'b1; gm_we = 1'b0; gm_addr = 8'h35; gm_wdata = 4'h0;
    cyc();
    check("abort_state", 8'(dut.state_r), 8'(GM_ISSUE));
    rst_n = 1'b0;
    #1;
    check("abort_ack0", 8'(gm_ack), 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort_noack", 8'(gm_ack), 8'h00);
    end
    rst_n = 1'b1;
    set_pix(96, 0, 1'b0);
    cur_exp = GROUND; tt_known = 1'b1;
    gm_access(1'b0, 8'h35, 4'h0, "reissue");
    repeat (40) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
